// File: rtl/store_align_buffer_if.sv
// ============================================================================
// store_align_buffer_if : store request and data-memory write bundles
// Revision: 1.0
// ============================================================================
`default_nettype none

interface store_req_if;
    logic        valid;
    logic        ready;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;

    modport master (output valid, output op, output addr, output data, input ready);
    modport slave  (input valid, input op, input addr, input data, output ready);
endinterface

interface mem_wr_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    modport master (output valid, output addr, output wdata, output wstrb, input ready);
    modport slave  (input valid, input addr, input wdata, input wstrb, output ready);
endinterface

`default_nettype wire

// File: rtl/store_align_buffer.sv
// ============================================================================
// store_align_buffer : SB/SH/SW lane alignment into a 2-entry write FIFO.
// Optional misalignment trap (ades) compiled in by STORE_ADES_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module store_align_buffer (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        flush_i,
    store_req_if.slave       req_if,
    mem_wr_if.master         wr_if,
    output logic [1:0]       count_o,
    output logic             ades_o,
    output logic [31:0]      ades_badvaddr_o
);

    localparam int unsigned DEPTH = 2;

    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] addr_q  [DEPTH];
    logic [31:0] wdata_q [DEPTH];
    logic [3:0]  wstrb_q [DEPTH];

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic        misaligned;
    logic        in_ready;
    logic        out_valid;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        lane_wdata = req_if.data;
        lane_wstrb = 4'b1111;
        case (req_if.op)
            2'b00: begin
                lane_wdata = {4{req_if.data[7:0]}};
                lane_wstrb = 4'b0001 << req_if.addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{req_if.data[15:0]}};
                lane_wstrb = req_if.addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = req_if.data;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

`ifdef STORE_ADES_CHECK_EN
    always_comb begin
        case (req_if.op)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_if.addr[0];
            default: misaligned = |req_if.addr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Ready comes from registered occupancy only, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = req_if.valid & in_ready;
    assign push      = accept & ~misaligned & ~flush_i;
    assign pop       = out_valid & wr_if.ready;

    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= 32'd0;
                wdata_q[i] <= 32'd0;
                wstrb_q[i] <= 4'd0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                addr_q[wr_ptr_q]  <= {req_if.addr[31:2], 2'b00};
                wdata_q[wr_ptr_q] <= lane_wdata;
                wstrb_q[wr_ptr_q] <= lane_wstrb;
            end
        end
    end

`ifdef STORE_ADES_CHECK_EN
    logic        ades_q, ades_d;
    logic [31:0] badvaddr_q;

    assign ades_d = accept & misaligned & ~flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ades_q     <= 1'b0;
            badvaddr_q <= 32'd0;
        end else begin
            ades_q <= ades_d;
            if (ades_d) begin
                badvaddr_q <= req_if.addr;
            end
        end
    end

    assign ades_o          = ades_q;
    assign ades_badvaddr_o = badvaddr_q;
`else
    assign ades_o          = 1'b0;
    assign ades_badvaddr_o = 32'd0;
`endif

    assign req_if.ready = in_ready;
    assign wr_if.valid  = out_valid;
    assign wr_if.addr   = addr_q[rd_ptr_q];
    assign wr_if.wdata  = wdata_q[rd_ptr_q];
    assign wr_if.wstrb  = out_valid ? wstrb_q[rd_ptr_q] : 4'b0000;
    assign count_o      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_store_align_buffer.sv
// ============================================================================
// tb_store_align_buffer : directed checks of alignment, FIFO flow, flush, reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_store_align_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  count;
    logic        ades;
    logic [31:0] badvaddr;

    int errors = 0;
    int checks = 0;

    store_req_if req ();
    mem_wr_if    wr ();

    store_align_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .req_if          (req),
        .wr_if           (wr),
        .count_o         (count),
        .ades_o          (ades),
        .ades_badvaddr_o (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        req.valid = v;
        req.op    = op;
        req.addr  = a;
        req.data  = d;
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        wr.ready = 1'b0;
        drv(1'b0, 2'b00, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        chk("rst_count",    {30'd0, count}, 32'd0);
        chk("rst_valid",    {31'd0, wr.valid}, 32'd0);
        chk("rst_addr",     wr.addr, 32'd0);
        chk("rst_wdata",    wr.wdata, 32'd0);
        chk("rst_wstrb",    {28'd0, wr.wstrb}, 32'd0);
        chk("rst_ades",     {31'd0, ades}, 32'd0);
        chk("rst_badvaddr", badvaddr, 32'd0);
        chk("rst_in_ready", {31'd0, req.ready}, 32'd1);
        rst = 1'b0;
        step();

        // SB at byte 3 with the sink ready: visible for one cycle, then drained
        wr.ready = 1'b1;
        drv(1'b1, 2'b00, 32'h1000_0003, 32'h1234_56AB);
        step();
        chk("sb3_count", {30'd0, count}, 32'd1);
        chk("sb3_valid", {31'd0, wr.valid}, 32'd1);
        chk("sb3_addr",  wr.addr, 32'h1000_0000);
        chk("sb3_wdata", wr.wdata, 32'hABAB_ABAB);
        chk("sb3_wstrb", {28'd0, wr.wstrb}, 32'h8);
        drv(1'b0, 2'b00, 32'd0, 32'd0);
        step();
        chk("drain_count", {30'd0, count}, 32'd0);
        chk("drain_valid", {31'd0, wr.valid}, 32'd0);
        chk("empty_wstrb", {28'd0, wr.wstrb}, 32'd0);

        // SB byte 1, then SH upper half pushed while SB pops
        wr.ready = 1'b0;
        drv(1'b1, 2'b00, 32'h0000_0001, 32'h0000_0055);
        step();
        chk("sb1_wstrb", {28'd0, wr.wstrb}, 32'h2);
        chk("sb1_wdata", wr.wdata, 32'h5555_5555);
        wr.ready = 1'b1;
        drv(1'b1, 2'b01, 32'h0000_0042, 32'hFFFF_BEEF);
        step();
        chk("sh42_count", {30'd0, count}, 32'd1);
        chk("sh42_addr",  wr.addr, 32'h0000_0040);
        chk("sh42_wdata", wr.wdata, 32'hBEEF_BEEF);
        chk("sh42_wstrb", {28'd0, wr.wstrb}, 32'hC);

        // Misaligned SH behind a held entry
        wr.ready = 1'b0;
        drv(1'b1, 2'b01, 32'h0000_0041, 32'h0000_CAFE);
        step();
`ifdef STORE_ADES_CHECK_EN
        chk("sh41_ades",     {31'd0, ades}, 32'd1);
        chk("sh41_badvaddr", badvaddr, 32'h0000_0041);
        chk("sh41_count",    {30'd0, count}, 32'd1);
`else
        chk("sh41_ades",  {31'd0, ades}, 32'd0);
        chk("sh41_count", {30'd0, count}, 32'd2);
`endif
        drv(1'b0, 2'b00, 32'd0, 32'd0);
        wr.ready = 1'b1;
        step();
`ifdef STORE_ADES_CHECK_EN
        chk("ades_pulse_end", {31'd0, ades}, 32'd0);
        chk("badvaddr_held",  badvaddr, 32'h0000_0041);
`else
        chk("sh40_addr",  wr.addr, 32'h0000_0040);
        chk("sh40_wdata", wr.wdata, 32'hCAFE_CAFE);
        chk("sh40_wstrb", {28'd0, wr.wstrb}, 32'h3);
`endif
        step();
        chk("sh_empty_count", {30'd0, count}, 32'd0);

        // Back-to-back misaligned SW
        drv(1'b1, 2'b10, 32'h0000_0007, 32'hCAFE_F00D);
        step();
`ifdef STORE_ADES_CHECK_EN
        chk("sw7_ades",     {31'd0, ades}, 32'd1);
        chk("sw7_badvaddr", badvaddr, 32'h0000_0007);
        chk("sw7_count",    {30'd0, count}, 32'd0);
`else
        chk("sw7_ades",  {31'd0, ades}, 32'd0);
        chk("sw7_addr",  wr.addr, 32'h0000_0004);
        chk("sw7_wstrb", {28'd0, wr.wstrb}, 32'hF);
        chk("sw7_wdata", wr.wdata, 32'hCAFE_F00D);
`endif
        drv(1'b1, 2'b11, 32'h0000_0009, 32'h0BAD_0009);
        step();
`ifdef STORE_ADES_CHECK_EN
        chk("sw9_ades",     {31'd0, ades}, 32'd1);
        chk("sw9_badvaddr", badvaddr, 32'h0000_0009);
`else
        chk("sw9_addr",  wr.addr, 32'h0000_0008);
        chk("sw9_count", {30'd0, count}, 32'd1);
`endif
        drv(1'b0, 2'b00, 32'd0, 32'd0);
        step();
        chk("sw9_drain_count", {30'd0, count}, 32'd0);
        chk("sw9_drain_ades",  {31'd0, ades}, 32'd0);

        // Full FIFO back-pressure and in-order drain
        wr.ready = 1'b0;
        drv(1'b1, 2'b10, 32'h0000_0100, 32'h1111_1111);
        step();
        drv(1'b1, 2'b10, 32'h0000_0204, 32'h2222_2222);
        step();
        chk("full_count",    {30'd0, count}, 32'd2);
        chk("full_in_ready", {31'd0, req.ready}, 32'd0);
        chk("full_head",     wr.addr, 32'h0000_0100);
        drv(1'b1, 2'b10, 32'h0000_0308, 32'h3333_3333);
        step();
        chk("held_count", {30'd0, count}, 32'd2);
        chk("held_wdata", wr.wdata, 32'h1111_1111);
        wr.ready = 1'b1;
        step();
        chk("pop1_count",    {30'd0, count}, 32'd1);
        chk("pop1_head",     wr.addr, 32'h0000_0204);
        chk("pop1_wdata",    wr.wdata, 32'h2222_2222);
        chk("pop1_in_ready", {31'd0, req.ready}, 32'd1);
        step();
        chk("pushpop_count", {30'd0, count}, 32'd1);
        chk("pushpop_head",  wr.addr, 32'h0000_0308);
        chk("pushpop_wdata", wr.wdata, 32'h3333_3333);
        drv(1'b0, 2'b00, 32'd0, 32'd0);
        step();
        chk("full_drain_count", {30'd0, count}, 32'd0);

        // Flush on a full FIFO, then flush racing a misaligned and an aligned accept
        wr.ready = 1'b0;
        drv(1'b1, 2'b10, 32'h0000_0400, 32'h4444_4444);
        step();
        drv(1'b1, 2'b10, 32'h0000_0500, 32'h5555_5555);
        step();
        chk("pre_flush_count", {30'd0, count}, 32'd2);
        flush = 1'b1;
        drv(1'b1, 2'b10, 32'h0000_0006, 32'h6666_6666);
        step();
        chk("flush_count", {30'd0, count}, 32'd0);
        chk("flush_valid", {31'd0, wr.valid}, 32'd0);
        chk("flush_ades",  {31'd0, ades}, 32'd0);
        step();
        chk("flush_mis_ades",  {31'd0, ades}, 32'd0);
        chk("flush_mis_count", {30'd0, count}, 32'd0);
        drv(1'b1, 2'b10, 32'h0000_0600, 32'h7777_7777);
        step();
        chk("flush_push_count", {30'd0, count}, 32'd0);
        flush = 1'b0;

        // Asynchronous reset with two entries queued
        drv(1'b1, 2'b10, 32'h0000_0700, 32'hAAAA_5555);
        step();
        drv(1'b1, 2'b10, 32'h0000_0704, 32'h5555_AAAA);
        step();
        drv(1'b0, 2'b00, 32'd0, 32'd0);
        chk("pre_rst_count", {30'd0, count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_count",    {30'd0, count}, 32'd0);
        chk("arst_valid",    {31'd0, wr.valid}, 32'd0);
        chk("arst_addr",     wr.addr, 32'd0);
        chk("arst_wdata",    wr.wdata, 32'd0);
        chk("arst_wstrb",    {28'd0, wr.wstrb}, 32'd0);
        chk("arst_ades",     {31'd0, ades}, 32'd0);
        chk("arst_badvaddr", badvaddr, 32'd0);
        chk("arst_in_ready", {31'd0, req.ready}, 32'd1);
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_align_buffer.md
# store_align_buffer

Store-side counterpart to the immediate/load extension path: it narrows and positions register data for SB/SH/SW into a word-aligned data-memory write. Sits between the MEM-stage store issue and the data-SRAM write port. Accepts one store request per cycle via valid/ready, converts it to word-address + lane-replicated write data + byte strobes, and holds up to two pending writes in a 2-entry FIFO. Misaligned stores are flagged as address errors.

## Interface
- DEPTH, 2, FIFO entries; fixed at 2, and the pointer widths assume it.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all queued entries (exception/eret)
- in_valid  input  1  store request valid
- in_ready  output  1  request accepted when in_valid & in_ready at rising edge
- in_op  input  2  00 SB, 01 SH, 10 SW, 11 treated as SW
- in_addr  input  32  byte virtual address
- in_data  input  32  rt register value
- out_valid  output  1  head entry valid
- out_ready  input  1  memory accepts head when out_valid & out_ready
- out_addr  output  32  word address, bits [1:0] always 0
- out_wdata  output  32  lane-replicated write data
- out_wstrb  output  4  byte enables, bit i = byte lane i (little-endian)
- count  output  2  occupancy, 0..2
- ades  output  1  one-cycle address-error-store pulse
- ades_badvaddr  output  32  faulting address, held until next ades

## Operation
- Alignment per accepted request:
  - SB: wdata = {4{data[7:0]}}; wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}; wstrb = addr[1] ? 4'b1100 : 4'b0011; misaligned if addr[0]=1.
  - SW/11: wdata = data; wstrb = 4'b1111; misaligned if addr[1:0] != 0.
  - out_addr = {addr[31:2], 2'b00}.
- in_ready = (count < 2). There is no pass-through when full, even if out_ready=1.
- Aligned accept: the entry is enqueued at the tail.
- Misaligned accept (with check compiled in): the request is consumed and not enqueued. ades=1 for the following cycle. ades_badvaddr = in_addr.
- Pop: out_valid & out_ready dequeues the head. out_* always reflect the head entry. When empty, out_wstrb = 0.
- Simultaneous push and pop with count=1: count stays 1, and the new entry becomes the head after the edge.
- Simultaneous push and pop with count=2: push cannot occur.
- flush=1 at an edge:
  - count -> 0 and out_valid -> 0.
  - A same-cycle push is dropped.
  - A same-cycle misaligned accept produces no ades.
  - A same-cycle pop is irrelevant.
- Pointers are 1-bit and wrap 1 -> 0.

## Timing
- Reset values: count=0, out_valid=0, out_addr=0, out_wdata=0, out_wstrb=0, ades=0, ades_badvaddr=0, in_ready=1, pointers=0.
- Latency: a request accepted at edge N is visible on out_* with out_valid=1 from edge N to N+1 when the FIFO was empty. Otherwise it appears when it reaches the head.
- ades is asserted for exactly the cycle after the accepting edge. Back-to-back misaligned stores give back-to-back ades pulses, with badvaddr updated each cycle.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- out_* must stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation clears all state immediately (asynchronously). Queued writes are discarded.

## Configuration
- STORE_ADES_CHECK_EN:
  - Defined: misalignment detection and ades/ades_badvaddr behave as above.
  - Undefined: no misalignment check. ades is tied 0 and ades_badvaddr is tied 0. Misaligned SH/SW are enqueued with the address aligned down and strobes computed from addr[1] (SH) or 4'b1111 (SW).

## Test plan
- Reset then SB addr=0x1000_0003 data=0x1234_56AB, out_ready=1 -> next cycle out_addr=0x1000_0000, out_wdata=0xABAB_ABAB, out_wstrb=4'b1000, count=1.
- SH addr=0x0000_0042 data=0xFFFF_BEEF -> out_wdata=0xBEEF_BEEF, out_wstrb=4'b1100. SH addr=0x41 -> ades=1 next cycle, ades_badvaddr=0x41, count unchanged.
- out_ready=0, three SW pushes -> first two accepted, count=2, in_ready=0. Third is held by the source. Raise out_ready -> entries drain in order, and the third is accepted the cycle after count drops to 1.
- count=1 with simultaneous push and pop -> count stays 1, and out_* show the new entry on the following cycle.
- count=2, flush=1 with a concurrent misaligned SW at 0x6 -> count=0, out_valid=0, ades stays 0.
- Assert rst while count=2 -> all outputs return to reset values without waiting for a clock edge. Also build with STORE_ADES_CHECK_EN undefined: SW at 0x7 is enqueued with out_addr=0x4, out_wstrb=4'b1111, and ades=0.
